// File: rtl/cdb_arbiter.sv
// Two-source arbiter for the single ROB result-write port (common data bus).
// Each source owns a one-entry holding slot; contention is resolved round-robin.
module cdb_arbiter #(
    parameter int IDX_W  = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              Clear_flag,
    input  logic              s0_valid,
    output logic              s0_ready,
    input  logic [IDX_W-1:0]  s0_rob_id,
    input  logic [DATA_W-1:0] s0_value,
    input  logic [DATA_W-1:0] s0_jumppc,
    input  logic              s0_jumppc_vld,
    input  logic              s1_valid,
    output logic              s1_ready,
    input  logic [IDX_W-1:0]  s1_rob_id,
    input  logic [DATA_W-1:0] s1_value,
    output logic              cdb_valid,
    output logic [IDX_W-1:0]  cdb_rob_id,
    output logic [DATA_W-1:0] cdb_value,
    output logic [DATA_W-1:0] cdb_jumppc,
    output logic              cdb_jumppc_vld,
    output logic              cdb_src
);

    logic              h0_valid_reg;
    logic [IDX_W-1:0]  h0_rob_id_reg;
    logic [DATA_W-1:0] h0_value_reg;
    logic [DATA_W-1:0] h0_jumppc_reg;
    logic              h0_jumppc_vld_reg;
    logic              h1_valid_reg;
    logic [IDX_W-1:0]  h1_rob_id_reg;
    logic [DATA_W-1:0] h1_value_reg;
    logic              rr_last_reg;

    logic live;
    logic g0;
    logic g1;
    logic acc0;
    logic acc1;

    // rr_last_reg==1 means the SLB won last, so the ALU takes the next tie.
    assign live     = rdy & ~Clear_flag;
    assign g0       = h0_valid_reg & (~h1_valid_reg | rr_last_reg);
    assign g1       = h1_valid_reg & ~g0;
    assign s0_ready = live & (~h0_valid_reg | g0);
    assign s1_ready = live & (~h1_valid_reg | g1);
    assign acc0     = s0_valid & s0_ready;
    assign acc1     = s1_valid & s1_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            h0_valid_reg      <= 1'b0;
            h0_rob_id_reg     <= '0;
            h0_value_reg      <= '0;
            h0_jumppc_reg     <= '0;
            h0_jumppc_vld_reg <= 1'b0;
            h1_valid_reg      <= 1'b0;
            h1_rob_id_reg     <= '0;
            h1_value_reg      <= '0;
            rr_last_reg       <= 1'b1;
            cdb_valid         <= 1'b0;
            cdb_rob_id        <= '0;
            cdb_value         <= '0;
            cdb_jumppc        <= '0;
            cdb_jumppc_vld    <= 1'b0;
            cdb_src           <= 1'b0;
        end else if (rdy) begin
            if (Clear_flag) begin
                // In-flight results die with the ROB flush.
                h0_valid_reg <= 1'b0;
                h1_valid_reg <= 1'b0;
                cdb_valid    <= 1'b0;
                rr_last_reg  <= 1'b1;
            end else begin
                if (g0) begin
                    cdb_valid      <= 1'b1;
                    cdb_rob_id     <= h0_rob_id_reg;
                    cdb_value      <= h0_value_reg;
                    cdb_jumppc     <= h0_jumppc_reg;
                    cdb_jumppc_vld <= h0_jumppc_vld_reg;
                    cdb_src        <= 1'b0;
                    rr_last_reg    <= 1'b0;
                end else if (g1) begin
                    cdb_valid      <= 1'b1;
                    cdb_rob_id     <= h1_rob_id_reg;
                    cdb_value      <= h1_value_reg;
                    cdb_jumppc     <= '0;
                    cdb_jumppc_vld <= 1'b0;
                    cdb_src        <= 1'b1;
                    rr_last_reg    <= 1'b1;
                end else begin
                    cdb_valid <= 1'b0;
                end

                // A granted slot may be refilled in the same cycle it drains.
                if (acc0) begin
                    h0_valid_reg      <= 1'b1;
                    h0_rob_id_reg     <= s0_rob_id;
                    h0_value_reg      <= s0_value;
                    h0_jumppc_reg     <= s0_jumppc;
                    h0_jumppc_vld_reg <= s0_jumppc_vld;
                end else if (g0) begin
                    h0_valid_reg <= 1'b0;
                end

                if (acc1) begin
                    h1_valid_reg  <= 1'b1;
                    h1_rob_id_reg <= s1_rob_id;
                    h1_value_reg  <= s1_value;
                end else if (g1) begin
                    h1_valid_reg <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: vector table, directed corner sequences, and random
// traffic checked against a slot/turn reference model.
module tb_cdb_arbiter;

    logic        clk = 1'b0;
    logic        rst, rdy, clear_flag;
    logic        s0_valid, s0_ready, s0_jumppc_vld;
    logic [4:0]  s0_rob_id;
    logic [31:0] s0_value, s0_jumppc;
    logic        s1_valid, s1_ready;
    logic [4:0]  s1_rob_id;
    logic [31:0] s1_value;
    logic        cdb_valid, cdb_jumppc_vld, cdb_src;
    logic [4:0]  cdb_rob_id;
    logic [31:0] cdb_value, cdb_jumppc;

    always #5 clk = ~clk;

    cdb_arbiter #(.IDX_W(5), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .Clear_flag(clear_flag),
        .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_rob_id(s0_rob_id),
        .s0_value(s0_value), .s0_jumppc(s0_jumppc), .s0_jumppc_vld(s0_jumppc_vld),
        .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_rob_id(s1_rob_id),
        .s1_value(s1_value),
        .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_value(cdb_value),
        .cdb_jumppc(cdb_jumppc), .cdb_jumppc_vld(cdb_jumppc_vld), .cdb_src(cdb_src)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit use_model = 0;
    bit alt_on = 0;
    int alt_n = 0;

    // Reference model: a pending slot per source plus the source favoured on a tie.
    bit          m_pv[2];
    logic [4:0]  m_pid[2];
    logic [31:0] m_pval[2];
    logic [31:0] m_pjpc;
    bit          m_pjv;
    int          m_turn;
    bit          m_cv, m_cjv, m_csrc;
    logic [4:0]  m_cid;
    logic [31:0] m_cval, m_cjpc;
    bit          e_r0, e_r1, m_acc0, m_acc1;
    int          e_w;

    typedef struct {
        int rst_n, rdy, clr, v0, id0, val0, jpc0, jv0, v1, id1, val1;
        int r0, r1, cv, cid, cval, cjpc, cjv, csrc;
    } vec_t;
    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_winner();
        if (m_pv[0] && m_pv[1]) return m_turn;
        if (m_pv[0]) return 0;
        if (m_pv[1]) return 1;
        return -1;
    endfunction

    task automatic m_step();
        m_acc0 = 0;
        m_acc1 = 0;
        if (!rst) begin
            m_pv[0] = 0; m_pv[1] = 0; m_turn = 0;
            m_cv = 0; m_cid = '0; m_cval = '0; m_cjpc = '0; m_cjv = 0; m_csrc = 0;
        end else if (rdy) begin
            if (clear_flag) begin
                m_pv[0] = 0; m_pv[1] = 0; m_cv = 0; m_turn = 0;
            end else begin
                if (e_w >= 0) begin
                    m_cv   = 1;
                    m_cid  = m_pid[e_w];
                    m_cval = m_pval[e_w];
                    m_cjpc = (e_w == 0) ? m_pjpc : 32'h0;
                    m_cjv  = (e_w == 0) ? m_pjv : 1'b0;
                    m_csrc = (e_w == 1);
                    m_turn = 1 - e_w;
                    m_pv[e_w] = 0;
                end else begin
                    m_cv = 0;
                end
                if (s0_valid && e_r0) begin
                    m_pv[0] = 1; m_pid[0] = s0_rob_id; m_pval[0] = s0_value;
                    m_pjpc = s0_jumppc; m_pjv = s0_jumppc_vld; m_acc0 = 1;
                end
                if (s1_valid && e_r1) begin
                    m_pv[1] = 1; m_pid[1] = s1_rob_id; m_pval[1] = s1_value; m_acc1 = 1;
                end
            end
        end
    endtask

    task automatic half_a();
        @(negedge clk);
        e_w  = m_winner();
        e_r0 = rdy && !clear_flag && (!m_pv[0] || e_w == 0);
        e_r1 = rdy && !clear_flag && (!m_pv[1] || e_w == 1);
        if (use_model) begin
            chk("s0_ready", 32'(s0_ready), 32'(e_r0));
            chk("s1_ready", 32'(s1_ready), 32'(e_r1));
            chk("cdb_valid", 32'(cdb_valid), 32'(m_cv));
            chk("cdb_rob_id", 32'(cdb_rob_id), 32'(m_cid));
            chk("cdb_value", cdb_value, m_cval);
            chk("cdb_jumppc", cdb_jumppc, m_cjpc);
            chk("cdb_jumppc_vld", 32'(cdb_jumppc_vld), 32'(m_cjv));
            chk("cdb_src", 32'(cdb_src), 32'(m_csrc));
        end
        if (alt_on && cdb_valid === 1'b1) begin
            chk("alternation", 32'(cdb_src), 32'(alt_n % 2));
            alt_n++;
        end
        if (cdb_valid === 1'b1)
            $display("cdb: id=%0d src=%0d value=0x%08h jumppc=0x%08h jv=%0d",
                     cdb_rob_id, cdb_src, cdb_value, cdb_jumppc, cdb_jumppc_vld);
    endtask

    task automatic half_b();
        @(posedge clk);
        m_step();
        #1;
    endtask

    task automatic tick();
        half_a();
        half_b();
    endtask

    task automatic idle_inputs();
        clear_flag = 0; s0_valid = 0; s1_valid = 0; s0_jumppc_vld = 0;
        s0_rob_id = '0; s0_value = '0; s0_jumppc = '0; s1_rob_id = '0; s1_value = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rdy = 1; rst = 0;
        tick();
        rst = 1;
    endtask

    initial begin
        // rst  rdy clr v0 id0 val0   jpc0   jv0 v1 id1 val1  | r0 r1 cv cid cval   cjpc   cjv src
        vecs[0]  = '{0, 1, 0, 0, 0, 0,     0,     0, 0, 0, 0,     1, 1, 0, 0, 0,     0,     0, 0};
        vecs[1]  = '{0, 1, 0, 0, 0, 0,     0,     0, 0, 0, 0,     1, 1, 0, 0, 0,     0,     0, 0};
        vecs[2]  = '{1, 1, 0, 1, 3, 'h11,  'h100, 1, 0, 0, 0,     1, 1, 0, 0, 0,     0,     0, 0};
        vecs[3]  = '{1, 1, 0, 0, 0, 0,     0,     0, 0, 0, 0,     1, 1, 0, 0, 0,     0,     0, 0};
        vecs[4]  = '{1, 1, 0, 0, 0, 0,     0,     0, 0, 0, 0,     1, 1, 1, 3, 'h11,  'h100, 1, 0};
        vecs[5]  = '{0, 1, 0, 0, 0, 0,     0,     0, 0, 0, 0,     1, 1, 0, 3, 'h11,  'h100, 1, 0};
        vecs[6]  = '{1, 1, 0, 1, 4, 'h44,  0,     0, 1, 5, 'h55,  1, 1, 0, 0, 0,     0,     0, 0};
        vecs[7]  = '{1, 1, 0, 0, 0, 0,     0,     0, 1, 6, 'h66,  1, 0, 0, 0, 0,     0,     0, 0};
        vecs[8]  = '{1, 1, 0, 0, 0, 0,     0,     0, 1, 6, 'h66,  1, 1, 1, 4, 'h44,  0,     0, 0};
        vecs[9]  = '{1, 1, 0, 0, 0, 0,     0,     0, 0, 0, 0,     1, 1, 1, 5, 'h55,  0,     0, 1};
        vecs[10] = '{1, 1, 0, 0, 0, 0,     0,     0, 0, 0, 0,     1, 1, 1, 6, 'h66,  0,     0, 1};
        vecs[11] = '{1, 1, 0, 0, 0, 0,     0,     0, 0, 0, 0,     1, 1, 0, 6, 'h66,  0,     0, 1};

        do_reset();

        // Vector table: reset, lone ALU result, contention and a blocked re-offer.
        foreach (vecs[i]) begin
            rst = 1'(vecs[i].rst_n); rdy = 1'(vecs[i].rdy); clear_flag = 1'(vecs[i].clr);
            s0_valid = 1'(vecs[i].v0); s0_rob_id = 5'(vecs[i].id0);
            s0_value = vecs[i].val0; s0_jumppc = vecs[i].jpc0; s0_jumppc_vld = 1'(vecs[i].jv0);
            s1_valid = 1'(vecs[i].v1); s1_rob_id = 5'(vecs[i].id1); s1_value = vecs[i].val1;
            half_a();
            chk($sformatf("v%0d.s0_ready", i), 32'(s0_ready), vecs[i].r0);
            chk($sformatf("v%0d.s1_ready", i), 32'(s1_ready), vecs[i].r1);
            chk($sformatf("v%0d.cdb_valid", i), 32'(cdb_valid), vecs[i].cv);
            chk($sformatf("v%0d.cdb_rob_id", i), 32'(cdb_rob_id), vecs[i].cid);
            chk($sformatf("v%0d.cdb_value", i), cdb_value, vecs[i].cval);
            chk($sformatf("v%0d.cdb_jumppc", i), cdb_jumppc, vecs[i].cjpc);
            chk($sformatf("v%0d.cdb_jumppc_vld", i), 32'(cdb_jumppc_vld), vecs[i].cjv);
            chk($sformatf("v%0d.cdb_src", i), 32'(cdb_src), vecs[i].csrc);
            half_b();
        end

        use_model = 1;

        // Both sources offering continuously: grants must alternate starting with the ALU.
        do_reset();
        begin
            int id0 = 0;
            int id1 = 16;
            alt_on = 1; alt_n = 0;
            for (int c = 0; c < 8; c++) begin
                s0_valid = 1; s0_rob_id = 5'(id0); s0_value = 32'h1000 + 32'(id0);
                s0_jumppc = 32'h2000 + 32'(id0); s0_jumppc_vld = 1'(id0 % 2);
                s1_valid = 1; s1_rob_id = 5'(id1); s1_value = 32'h3000 + 32'(id1);
                tick();
                if (m_acc0) id0++;
                if (m_acc1) id1++;
            end
            idle_inputs();
            for (int c = 0; c < 4; c++) tick();
            chk("alt_grant_count", 32'(alt_n), 32'(id0 + id1 - 16));
            alt_on = 0;
        end

        // Flush with both slots full: nothing old may be broadcast afterwards.
        do_reset();
        s0_valid = 1; s0_rob_id = 5'd20; s0_value = 32'hA0; s1_valid = 1; s1_rob_id = 5'd21; s1_value = 32'hA1;
        tick();
        idle_inputs();
        clear_flag = 1;
        tick();
        clear_flag = 0;
        half_a();
        chk("clr.cdb_valid", 32'(cdb_valid), 32'd0);
        chk("clr.s0_ready", 32'(s0_ready), 32'd1);
        chk("clr.s1_ready", 32'(s1_ready), 32'd1);
        half_b();
        for (int c = 0; c < 3; c++) begin
            half_a();
            chk("clr.quiet", 32'(cdb_valid), 32'd0);
            half_b();
        end

        // Freeze with slots full, even while a flush is requested, then resume in order.
        do_reset();
        s0_valid = 1; s0_rob_id = 5'd9; s0_value = 32'h99; s0_jumppc = 32'h900; s0_jumppc_vld = 1;
        s1_valid = 1; s1_rob_id = 5'd10; s1_value = 32'hAA;
        tick();
        rdy = 0; clear_flag = 1;
        s0_rob_id = 5'd11; s1_rob_id = 5'd12;
        for (int c = 0; c < 3; c++) begin
            half_a();
            chk("frz.s0_ready", 32'(s0_ready), 32'd0);
            chk("frz.s1_ready", 32'(s1_ready), 32'd0);
            half_b();
        end
        idle_inputs();
        rdy = 1;
        tick();
        half_a();
        chk("frz.first_id", 32'(cdb_rob_id), 32'd9);
        chk("frz.first_jpc", cdb_jumppc, 32'h900);
        half_b();
        half_a();
        chk("frz.second_id", 32'(cdb_rob_id), 32'd10);
        chk("frz.second_src", 32'(cdb_src), 32'd1);
        half_b();

        // Random traffic against the reference model.
        for (int c = 0; c < 800; c++) begin
            rst        = ($urandom_range(99) != 0);
            rdy        = ($urandom_range(99) >= 15);
            clear_flag = ($urandom_range(99) < 5);
            s0_valid   = ($urandom_range(99) < 65);
            s0_rob_id  = 5'($urandom);
            s0_value   = $urandom;
            s0_jumppc  = $urandom;
            s0_jumppc_vld = 1'($urandom);
            s1_valid   = ($urandom_range(99) < 65);
            s1_rob_id  = 5'($urandom);
            s1_value   = $urandom;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
